alpharetz_operand_fetch: RTL

ALPHARETZ_OPERAND_FETCH -- requirements
Module: alpharetz_operand_fetch

---
 rtl/alpharetz_operand_fetch_if.sv | 58 +++++
 rtl/alpharetz_operand_fetch.sv | 133 +++++++++++++
 2 files changed

// File: rtl/alpharetz_operand_fetch_if.sv
// Operand-fetch stage bundle: decode handshake, regfile read ports, writeback
// snoop, execute handshake and stage control.
interface alpharetz_operand_fetch_if #(
    parameter int CPU_DATA_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      clk_en;
    logic                      sys_en;
    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [REG_ADDR_WIDTH-1:0] in_rs1;
    logic [REG_ADDR_WIDTH-1:0] in_rs2;
    logic                      in_rs1_use;
    logic                      in_rs2_use;
    logic [REG_ADDR_WIDTH-1:0] in_rd;
    logic                      in_rd_wr;
    logic                      rd_en_a;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_a;
    logic [CPU_DATA_WIDTH-1:0] rd_data_a;
    logic                      rd_en_b;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_b;
    logic [CPU_DATA_WIDTH-1:0] rd_data_b;
    logic                      wb_en;
    logic [REG_ADDR_WIDTH-1:0] wb_addr;
    logic [CPU_DATA_WIDTH-1:0] wb_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [CPU_DATA_WIDTH-1:0] out_op_a;
    logic [CPU_DATA_WIDTH-1:0] out_op_b;
    logic [REG_ADDR_WIDTH-1:0] out_rd;
    logic                      out_rd_wr;
    logic [15:0]               stall_count;

    modport slave (
        input  clk_en, sys_en, flush,
        input  in_valid, in_rs1, in_rs2, in_rs1_use, in_rs2_use, in_rd, in_rd_wr,
        output in_ready,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  rd_data_a, rd_data_b,
        input  wb_en, wb_addr, wb_data,
        output out_valid, out_op_a, out_op_b, out_rd, out_rd_wr,
        input  out_ready,
        output stall_count
    );

    modport master (
        output clk_en, sys_en, flush,
        output in_valid, in_rs1, in_rs2, in_rs1_use, in_rs2_use, in_rd, in_rd_wr,
        input  in_ready,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output rd_data_a, rd_data_b,
        output wb_en, wb_addr, wb_data,
        input  out_valid, out_op_a, out_op_b, out_rd, out_rd_wr,
        output out_ready,
        input  stall_count
    );
endinterface

// File: rtl/alpharetz_operand_fetch.sv
// Operand fetch stage: scoreboard hazard check, writeback bypass and a single
// output holding register toward execute.
module alpharetz_operand_fetch #(
    parameter int CPU_DATA_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CPU_REG_COUNT  = 32
) (
    input  logic                       clk,
    input  logic                       async_rst_n,
    alpharetz_operand_fetch_if.slave   bus
);
    // state    | meaning
    // ST_EMPTY | no instruction held for execute
    // ST_HELD  | operands held, out_valid asserted
    typedef enum logic {ST_EMPTY, ST_HELD} state_t;

    state_t                    state_q, state_d;
    logic [CPU_REG_COUNT-1:0]  busy, busy_d;
    logic [CPU_DATA_WIDTH-1:0] op_a_q, op_b_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;
    logic                      rd_wr_q;
    logic [15:0]               stall_q;

    logic adv, hazard, accept, out_valid;
    logic haz_rs1, haz_rs2, haz_rd;
    logic [CPU_DATA_WIDTH-1:0] op_a_d, op_b_d;

    function automatic logic is_busy(input logic [CPU_REG_COUNT-1:0]  v,
                                     input logic [REG_ADDR_WIDTH-1:0] a);
        is_busy = (32'(a) < CPU_REG_COUNT) ? v[a] : 1'b0;
    endfunction

    function automatic logic [CPU_DATA_WIDTH-1:0] pick_operand(
        input logic                      use_src,
        input logic [REG_ADDR_WIDTH-1:0] addr,
        input logic [CPU_DATA_WIDTH-1:0] rf_data,
        input logic                      wb_en,
        input logic [REG_ADDR_WIDTH-1:0] wb_addr,
        input logic [CPU_DATA_WIDTH-1:0] wb_data
    );
        if (!use_src || addr == '0)
            pick_operand = '0;
        else if (wb_en && wb_addr == addr)
            pick_operand = wb_data;
        else
            pick_operand = rf_data;
    endfunction

    assign adv       = bus.clk_en && bus.sys_en;
    assign out_valid = (state_q == ST_HELD);

    // A writeback landing this cycle resolves the hazard through the bypass.
    assign haz_rs1 = bus.in_rs1_use && is_busy(busy, bus.in_rs1)
                     && !(bus.wb_en && bus.wb_addr == bus.in_rs1);
    assign haz_rs2 = bus.in_rs2_use && is_busy(busy, bus.in_rs2)
                     && !(bus.wb_en && bus.wb_addr == bus.in_rs2);
    assign haz_rd  = bus.in_rd_wr && is_busy(busy, bus.in_rd)
                     && !(bus.wb_en && bus.wb_addr == bus.in_rd);
    assign hazard  = haz_rs1 || haz_rs2 || haz_rd;

    assign bus.in_ready = adv && !bus.flush && !hazard && (!out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.rd_en_a   = bus.in_rs1_use;
    assign bus.rd_addr_a = bus.in_rs1;
    assign bus.rd_en_b   = bus.in_rs2_use;
    assign bus.rd_addr_b = bus.in_rs2;

    assign op_a_d = pick_operand(bus.in_rs1_use, bus.in_rs1, bus.rd_data_a,
                                 bus.wb_en, bus.wb_addr, bus.wb_data);
    assign op_b_d = pick_operand(bus.in_rs2_use, bus.in_rs2, bus.rd_data_b,
                                 bus.wb_en, bus.wb_addr, bus.wb_data);

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_q <= ST_EMPTY;
            busy    <= '0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
        end
    end

    // Clears are applied before the set so a same-cycle set wins.
    always_comb begin
        state_d = state_q;
        busy_d  = busy;
        if (adv) begin
            if (bus.wb_en && bus.wb_addr != '0)
                busy_d[bus.wb_addr] = 1'b0;
            if (bus.flush) begin
                if (out_valid && rd_wr_q)
                    busy_d[rd_q] = 1'b0;
                state_d = ST_EMPTY;
            end else if (accept) begin
                if (bus.in_rd_wr && bus.in_rd != '0)
                    busy_d[bus.in_rd] = 1'b1;
                state_d = ST_HELD;
            end else if (out_valid && bus.out_ready) begin
                state_d = ST_EMPTY;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            op_a_q  <= '0;
            op_b_q  <= '0;
            rd_q    <= '0;
            rd_wr_q <= 1'b0;
        end else if (accept) begin
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            rd_q    <= bus.in_rd;
            rd_wr_q <= bus.in_rd_wr;
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n)
            stall_q <= '0;
        else if (adv && bus.in_valid && hazard && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign bus.out_valid   = out_valid;
    assign bus.out_op_a    = op_a_q;
    assign bus.out_op_b    = op_b_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_rd_wr   = rd_wr_q;
    assign bus.stall_count = stall_q;
endmodule
